// File: rtl/seg7_scan_n.sv
// seg7_scan_n: time-multiplexed driver for a bank of seven-segment digits.
// Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYCLES of every
// slot are dark to hide ghosting while the digit drivers switch over. A 4-bit
// PWM sets the brightness, and leading zeros can be blanked. Inputs are
// captured once per frame so the displayed number never tears mid-scan.
module seg7_scan_n #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [4*DIGITS-1:0] iDIG,
    input  logic [DIGITS-1:0]   iDP,
    input  logic [DIGITS-1:0]   iEN,
    input  logic                iLZS,
    input  logic [3:0]          iBRIGHT,
    output logic [6:0]          oSEG,
    output logic                oDP,
    output logic [DIGITS-1:0]   oDIG,
    output logic                oFRAME
);

    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // XOR masks: an undriven output sits at these levels, and XOR-ing the
    // active-high value with them gives the pin polarity.
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    typedef struct packed {
        logic [4*DIGITS-1:0] dig;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   en;
        logic                lzs;
        logic [3:0]          bright;
    } shadow_t;

    logic [SC_W-1:0]   sc_q, sc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        pwm_q, pwm_d;
    shadow_t           sh_q, sh_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              frame_q, frame_d;

    logic              frame_start;
    logic              past_blank;
    logic [3:0]        sel_nib;
    logic              sel_dp;
    logic              sel_en;
    logic              sel_supp;
    logic [DIGITS-1:0] sel_onehot;
    logic [DIGITS-1:0] supp;
    logic              zero_run;
    logic              drive;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    // Dead time: with no blanking every slot cycle may light, which avoids
    // an always-true unsigned compare against zero.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (sc_q >= SC_W'(BLANK_CYCLES));
        end
    endgenerate

    // Slot counter, digit index and free-running PWM phase.
    always_comb begin
        frame_start = (sc_q == '0) && (idx_q == '0);
        pwm_d       = pwm_q + 4'd1;
        sc_d        = sc_q + SC_W'(1);
        idx_d       = idx_q;
        if (sc_q == SC_LAST) begin
            sc_d  = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Capture all inputs on the first cycle of a frame. Outputs produced on
    // that same cycle already use the fresh values.
    always_comb begin
        sh_d = sh_q;
        if (frame_start) begin
            sh_d.dig    = iDIG;
            sh_d.dp     = iDP;
            sh_d.en     = iEN;
            sh_d.lzs    = iLZS;
            sh_d.bright = iBRIGHT;
        end
    end

    // Leading-zero map, then pick out the scanned digit's nibble and flags.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sel_nib    = '0;
        sel_dp     = 1'b0;
        sel_en     = 1'b0;
        sel_supp   = 1'b0;
        sel_onehot = '0;
        supp       = '0;
        zero_run   = sh_d.lzs;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (sh_d.dig[4*i +: 4] == 4'h0);
            supp[i]  = zero_run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib       = sh_d.dig[4*i +: 4];
                sel_dp        = sh_d.dp[i];
                sel_en        = sh_d.en[i];
                sel_supp      = supp[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Gate the decode with dead time, PWM, enable and suppression, then apply polarity.
    always_comb begin
        drive   = past_blank && (pwm_q <= sh_d.bright) && sel_en && !sel_supp;
        seg_d   = (drive ? hex_to_seg(sel_nib) : 7'h00) ^ SEG_OFF;
        dp_d    = (drive && sel_dp) ^ DP_OFF;
        dig_d   = (drive ? sel_onehot : '0) ^ DIG_OFF;
        frame_d = frame_start;
    end

    // State and registered outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            // NOTE: the output flops reset to their inactive levels, so the display goes dark the moment reset asserts, with no clock edge needed.
            sc_q    <= '0;
            idx_q   <= '0;
            pwm_q   <= '0;
            sh_q    <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            dig_q   <= DIG_OFF;
            frame_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_d;
            sh_q    <= sh_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign oSEG   = seg_q;
    assign oDP    = dp_q;
    assign oDIG   = dig_q;
    assign oFRAME = frame_q;

endmodule
